// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared state encoding, default geometry and line-base helper for cache_mem_responder
package cache_mem_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WDATA  = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_RBURST = 3'd3;
  localparam state_t ST_WDONE  = 3'd4;

  localparam int unsigned DEF_MEM_WORDS  = 1024;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(DEF_MEM_WORDS);

  // Clears the in-line word offset so every burst starts on a line boundary.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port RAM, synchronous write and registered synchronous read
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Output register holds its value between reads so the last beat stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - backing memory serving cache line refills and writebacks with fixed latency
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              wr_done
);

  localparam int LOFF  = $clog2(LINE_WORDS);
  localparam int LIDX  = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t          state, state_nx;
  logic [LOFF-1:0] beat;
  logic [CNT_W-1:0] cnt;
  logic            wr_q;
  logic [LIDX-1:0] base_idx;
  logic            ready_q;
  logic [63:0]     base_ext;
  logic            unused_addr_bits;
  logic            accept;
  logic            last_beat;
  logic            ram_we, ram_re;
  logic [LIDX-1:0] ram_addr;

  assign base_ext         = line_base(64'(req_addr), LOFF);
  assign unused_addr_bits = ^base_ext[63:LIDX];
  assign accept           = req_valid & ready_q;
  assign last_beat        = (beat == LOFF'(LINE_WORDS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = req_wr ? ST_WDATA : ST_WAIT;
      ST_WDATA:  if (wdata_valid && last_beat) state_nx = ST_WAIT;
      ST_WAIT:   if (cnt == '0) state_nx = wr_q ? ST_WDONE : ST_RBURST;
      ST_RBURST: if (last_beat) state_nx = ST_IDLE;
      ST_WDONE:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      beat     <= '0;
      cnt      <= '0;
      wr_q     <= 1'b0;
      base_idx <= '0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx == ST_IDLE);
      case (state)
        ST_IDLE: if (accept) begin
          base_idx <= base_ext[LIDX-1:0];
          wr_q     <= req_wr;
          beat     <= '0;
          cnt      <= CNT_W'(LATENCY);
        end
        ST_WDATA: if (wdata_valid) begin
          beat <= beat + LOFF'(1);
          cnt  <= CNT_W'(LATENCY);
        end
        ST_WAIT:   if (cnt != '0) cnt <= cnt - CNT_W'(1);
        ST_RBURST: beat <= beat + LOFF'(1);
        default: ;
      endcase
    end
  end

  // Reads are issued one cycle ahead: the final WAIT cycle fetches beat 0, each burst cycle fetches the next.
  assign ram_we   = (state == ST_WDATA) && wdata_valid;
  assign ram_re   = ((state == ST_WAIT) && (cnt == '0) && !wr_q) ||
                    ((state == ST_RBURST) && !last_beat);
  assign ram_addr = base_idx | LIDX'((state == ST_RBURST) ? beat + LOFF'(1) : beat);

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_WORDS),
    .AW     (LIDX)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign req_ready   = ready_q;
  assign wdata_ready = (state == ST_WDATA);
  assign rdata_valid = (state == ST_RBURST);
  assign rdata_last  = (state == ST_RBURST) && last_beat;
  assign wr_done     = (state == ST_WDONE);

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - directed self-checking bench for cache_mem_responder
module tb_cache_mem_responder;

  localparam int L  = 8;
  localparam int LW = 4;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wdata_valid = 1'b0;
  logic [31:0] wdata = '0;
  logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_done;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail = 0;

  cache_mem_responder #(
    .DATA_W(32), .ADDR_W(32), .MEM_WORDS(MW), .LINE_WORDS(LW), .LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge inside the cycle that begins with the acceptance edge.
  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) expect_eq("accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [127:0] line,
                         input bit hold, input logic [31:0] next_a);
    int m = 0;
    int busy_rdy = 0;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = a;
    wait_accept();
    if (hold) req_addr = next_a;
    else      req_valid = 1'b0;
    while (!rdata_valid && m < 100) begin
      busy_rdy += int'(req_ready);
      @(negedge clk);
      m++;
    end
    expect_eq("rd_latency", 64'(m), 64'(L + 1));
    for (int b = 0; b < LW; b++) begin
      expect_eq("rd_valid", 64'(rdata_valid), 64'd1);
      expect_eq("rd_data", 64'(rdata), 64'(line[32*b +: 32]));
      expect_eq("rd_last", 64'(rdata_last), 64'(b == LW - 1));
      busy_rdy += int'(req_ready);
      @(negedge clk);
    end
    expect_eq("rd_busy_ready", 64'(busy_rdy), 64'd0);
    expect_eq("rd_end_valid", 64'(rdata_valid), 64'd0);
    expect_eq("rd_hold", 64'(rdata), 64'(line[32*(LW-1) +: 32]));
    expect_eq("rd_ready_back", 64'(req_ready), 64'd1);
  endtask

  // pat bit i gives wdata_valid for the i-th WDATA cycle (LSB first); beyond 32 cycles it is 1.
  task automatic do_write(input logic [31:0] a, input logic [127:0] line, input logic [31:0] pat);
    int beat = 0;
    int i = 0;
    int m = 0;
    logic v;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = a;
    wait_accept();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    expect_eq("wr_ready", 64'(wdata_ready), 64'd1);
    while (beat < LW && i < 64) begin
      v = (i < 32) ? pat[i] : 1'b1;
      wdata_valid = v;
      wdata = v ? line[32*beat +: 32] : 32'hBAD0_0000 + 32'(i);
      @(negedge clk);
      if (v) beat++;
      i++;
    end
    expect_eq("wr_ready_drop", 64'(wdata_ready), 64'd0);
    wdata_valid = 1'b1;
    wdata = 32'hDEAD_BEEF;
    while (!wr_done && m < 100) begin
      @(negedge clk);
      m++;
    end
    expect_eq("wr_done_lat", 64'(m), 64'(L + 1));
    @(negedge clk);
    expect_eq("wr_done_pulse", 64'(wr_done), 64'd0);
    expect_eq("wr_ready_back", 64'(req_ready), 64'd1);
    wdata_valid = 1'b0;
  endtask

  initial begin
    int m;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h40;
    repeat (3) begin
      @(negedge clk);
      expect_eq("rst_outs", 64'({req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, rdata}), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    expect_eq("rst_ready", 64'(req_ready), 64'd1);
    expect_eq("rst_no_accept", 64'({wdata_ready, rdata_valid}), 64'd0);
    req_valid = 1'b0;

    do_read(32'h10, 128'd0, 1'b0, 32'h0);

    do_write(32'h23, {32'h7, 32'h5, 32'h3, 32'h1}, 32'hFFFF_FFFF);
    do_read(32'h21, {32'h7, 32'h5, 32'h3, 32'h1}, 1'b0, 32'h0);

    do_write(32'h30, {32'h44, 32'h33, 32'h22, 32'h11}, 32'b1011001);
    do_read(32'h32, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 32'h0);
    do_read(32'h34, 128'd0, 1'b0, 32'h0);

    do_write(32'(MW + 4), {32'hD, 32'hC, 32'hB, 32'hA}, 32'hFFFF_FFFF);
    do_read(32'h4, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b1, 32'h20);
    do_read(32'h20, {32'h7, 32'h5, 32'h3, 32'h1}, 1'b0, 32'h0);

    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 32'h22;
    wait_accept();
    req_valid = 1'b0;
    m = 0;
    while (!rdata_valid && m < 100) begin
      @(negedge clk);
      m++;
    end
    expect_eq("abort_latency", 64'(m), 64'(L + 1));
    @(negedge clk);
    expect_eq("abort_beat2", 64'({rdata_valid, rdata}), {31'd0, 1'b1, 32'h3});
    rst_n = 1'b0;
    #1;
    expect_eq("abort_outs", 64'({req_ready, rdata_valid, rdata_last, wr_done, rdata}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_eq("abort_ready", 64'(req_ready), 64'd1);
    do_read(32'h20, {32'h7, 32'h5, 32'h3, 32'h1}, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
